// File: rtl/serdes_pkg.sv
// Shared constants and helpers for the serializer/deserializer family.
// FSM encodings and the bit-counter width function.
package serdes_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Smallest w with 2**w >= n, never less than 1 so counters stay legal.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((33'd1 << i) < 33'(n)) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/piso_hold_reg.sv
// One-word holding buffer with valid/ready load side and a take strobe
// used by the shifter to consume the buffered word.
module piso_hold_reg
  import serdes_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             take,
  output logic [WIDTH-1:0] hold_data,
  output logic             hold_full
);

  logic [WIDTH-1:0] r_data;
  logic             r_empty;
  logic             w_accept;

  assign w_accept = load_valid && r_empty;

  // take only happens while full, so it can never collide with an accept
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_data  <= '0;
      r_empty <= 1'b1;
    end else begin
      if (w_accept) begin
        r_data  <= load_data;
        r_empty <= 1'b0;
      end else if (take) begin
        r_empty <= 1'b1;
      end
    end
  end

  assign load_ready = r_empty;
  assign hold_data  = r_data;
  assign hold_full  = !r_empty;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with a one-word holding buffer,
// gapless back-to-back frames, selectable bit order and frame markers.
module piso_serializer
  import serdes_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             frame_end
);

  localparam int unsigned      CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_nxt;
  logic [WIDTH-1:0] w_sr_shifted;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_take;
  logic             w_hold_full;
  logic [WIDTH-1:0] w_hold_data;
  logic             w_shift_nxt;
  logic             w_bit_nxt;

  logic r_serial_out;
  logic r_serial_valid;
  logic r_frame_start;
  logic r_frame_end;

  piso_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk        (clk),
    .clr_n      (clr_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (parallel_in),
    .take       (w_take),
    .hold_data  (w_hold_data),
    .hold_full  (w_hold_full)
  );

  // Move one place toward the output end, zero-filling behind.
  always_comb begin
    w_sr_shifted = '0;
    if (LSB_FIRST) w_sr_shifted = {1'b0, r_sr[WIDTH-1:1]};
    else           w_sr_shifted = {r_sr[WIDTH-2:0], 1'b0};
  end

  // Next-state, shifter and counter decode.
  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_cnt_nxt   = r_cnt;
    w_take      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_hold_full && en) begin
          w_take      = 1'b1;
          w_sr_nxt    = w_hold_data;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (en) begin
          if (r_cnt != CNT_LAST) begin
            w_sr_nxt  = w_sr_shifted;
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end else if (w_hold_full) begin
            w_take    = 1'b1;
            w_sr_nxt  = w_hold_data;
            w_cnt_nxt = '0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= ST_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign w_shift_nxt = (w_state_nxt == ST_SHIFT);
  assign w_bit_nxt   = LSB_FIRST ? w_sr_nxt[0] : w_sr_nxt[WIDTH-1];

  // Outputs track the next state so they line up exactly with r_state/r_cnt.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_serial_out   <= 1'b0;
      r_serial_valid <= 1'b0;
      r_frame_start  <= 1'b0;
      r_frame_end    <= 1'b0;
    end else begin
      r_serial_out   <= w_shift_nxt && w_bit_nxt;
      r_serial_valid <= w_shift_nxt;
      r_frame_start  <= w_shift_nxt && (w_cnt_nxt == '0);
      r_frame_end    <= w_shift_nxt && (w_cnt_nxt == CNT_LAST);
    end
  end

  assign serial_out   = r_serial_out;
  assign serial_valid = r_serial_valid;
  assign frame_start  = r_frame_start;
  assign frame_end    = r_frame_end;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: one MSB-first and one LSB-first instance.
`timescale 1ns/1ps
module tb_piso_serializer;

  localparam int unsigned W = 16;

  typedef struct packed {
    logic sout;
    logic fs;
    logic fe;
  } exp_t;

  logic clk = 1'b0;
  logic clr_n;

  logic         en0, lv0, rdy0, so0, sv0, fs0, fe0;
  logic [W-1:0] pin0;
  logic         en1, lv1, rdy1, so1, sv1, fs1, fe1;
  logic [W-1:0] pin1;

  exp_t q0[$];
  exp_t q1[$];

  int tests = 0;
  int fails = 0;
  int run0 = 0, run1 = 0, last0 = 0, last1 = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .clr_n(clr_n), .en(en0), .load_valid(lv0), .load_ready(rdy0),
    .parallel_in(pin0), .serial_out(so0), .serial_valid(sv0),
    .frame_start(fs0), .frame_end(fe0)
  );

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .clr_n(clr_n), .en(en1), .load_valid(lv1), .load_ready(rdy1),
    .parallel_in(pin1), .serial_out(so1), .serial_valid(sv1),
    .frame_start(fs1), .frame_end(fe1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare the displayed bit with the queue head; pop when en lets it advance.
  always @(negedge clk) begin
    if (!clr_n) begin
      run0 = 0;
      run1 = 0;
    end else begin
      if (sv0) begin
        if (q0.size() == 0) begin
          tests++; fails++;
          $display("FAIL msb_unexpected_bit: got valid, expected idle at %0t", $time);
        end else begin
          chk("msb_bit", so0, q0[0].sout);
          chk("msb_start", fs0, q0[0].fs);
          chk("msb_end", fe0, q0[0].fe);
          if (en0) void'(q0.pop_front());
        end
        run0++;
      end else begin
        chk("msb_idle_out", {so0, fs0, fe0}, 0);
        if (run0 != 0) begin last0 = run0; run0 = 0; end
      end
      if (sv1) begin
        if (q1.size() == 0) begin
          tests++; fails++;
          $display("FAIL lsb_unexpected_bit: got valid, expected idle at %0t", $time);
        end else begin
          chk("lsb_bit", so1, q1[0].sout);
          chk("lsb_start", fs1, q1[0].fs);
          chk("lsb_end", fe1, q1[0].fe);
          if (en1) void'(q1.pop_front());
        end
        run1++;
      end else begin
        chk("lsb_idle_out", {so1, fs1, fe1}, 0);
        if (run1 != 0) begin last1 = run1; run1 = 0; end
      end
    end
  end

  // Offer a word until accepted; on acceptance queue its expected bit stream.
  task automatic push_word(input bit sel, input logic [W-1:0] d);
    bit acc = 1'b0;
    int n = 0;
    if (sel) begin lv1 = 1'b1; pin1 = d; end
    else     begin lv0 = 1'b1; pin0 = d; end
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = sel ? rdy1 : rdy0;
      @(posedge clk); #1;
      n++;
    end
    if (sel) lv1 = 1'b0; else lv0 = 1'b0;
    if (!acc) begin
      tests++; fails++;
      $display("FAIL load_timeout: got no accept, expected accept of %0h", d);
    end else begin
      for (int i = 0; i < int'(W); i++) begin
        exp_t e;
        e.sout = sel ? d[4'(i)] : d[4'(int'(W) - 1 - i)];
        e.fs   = (i == 0);
        e.fe   = (i == int'(W) - 1);
        if (sel) q1.push_back(e); else q0.push_back(e);
      end
    end
  endtask

  task automatic drain(input bit sel);
    int n = 0;
    while (((sel ? q1.size() : q0.size()) != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d bits left, expected 0", sel ? q1.size() : q0.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000ns");
    $fatal(1);
  end

  initial begin
    clr_n = 1'b0;
    en0 = 1'b1; en1 = 1'b1;
    lv0 = 1'b0; lv1 = 1'b0;
    pin0 = '0;  pin1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready0", rdy0, 1);
    chk("rst_outs0", {so0, sv0, fs0, fe0}, 0);
    chk("rst_ready1", rdy1, 1);
    chk("rst_outs1", {so1, sv1, fs1, fe1}, 0);
    clr_n = 1'b1;
    @(posedge clk); #1;

    // Single frame, MSB first, two-edge latency.
    push_word(1'b0, 16'hA5A5);
    chk("lat_valid_k", sv0, 0);
    chk("lat_ready_k", rdy0, 0);
    @(posedge clk); #1;
    chk("lat_valid_k1", sv0, 1);
    chk("lat_start_k1", fs0, 1);
    chk("lat_first_bit", so0, 1);
    chk("lat_ready_k1", rdy0, 1);
    drain(1'b0);
    chk("frame_len", last0, 16);

    // Back-to-back frames.
    push_word(1'b0, 16'hA5A5);
    push_word(1'b0, 16'h5555);
    drain(1'b0);
    chk("b2b_len", last0, 32);

    // LSB first.
    push_word(1'b1, 16'h0001);
    @(posedge clk); #1;
    chk("lsb_first_bit", so1, 1);
    @(posedge clk); #1;
    chk("lsb_second_bit", so1, 0);
    drain(1'b1);
    chk("lsb_len", last1, 16);

    // Three-cycle stall after bit 4.
    push_word(1'b0, 16'hA5A5);
    repeat (4) @(posedge clk);
    #1;
    chk("stall_bit4", so0, 0);
    en0 = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("stall_hold_bit", so0, 0);
      chk("stall_hold_valid", sv0, 1);
    end
    en0 = 1'b1;
    drain(1'b0);
    chk("stall_len", last0, 19);

    // en low in IDLE: first word buffered, second held off until transfer.
    en0 = 1'b0;
    push_word(1'b0, 16'h1234);
    fork
      push_word(1'b0, 16'hABCD);
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("held_ready", rdy0, 0);
        chk("held_idle", sv0, 0);
        en0 = 1'b1;
      end
    join
    drain(1'b0);
    chk("held_len", last0, 32);

    // Asynchronous reset mid-frame with a word buffered.
    push_word(1'b0, 16'hA5A5);
    push_word(1'b0, 16'hFFFF);
    repeat (6) @(posedge clk);
    #1;
    chk("pre_rst_valid", sv0, 1);
    clr_n = 1'b0;
    #1;
    chk("rst_mid_outs", {so0, sv0, fs0, fe0}, 0);
    chk("rst_mid_ready", rdy0, 1);
    q0.delete();
    repeat (2) @(posedge clk);
    #1;
    clr_n = 1'b1;
    push_word(1'b0, 16'h8001);
    @(posedge clk); #1;
    chk("post_rst_start", fs0, 1);
    chk("post_rst_bit", so0, 1);
    drain(1'b0);
    chk("post_rst_len", last0, 16);

    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parametrised parallel-in/serial-out serializer with a one-word holding buffer, valid/ready load handshake, selectable bit order and frame markers. It is the successor to the team's fixed 16-bit shift-enable PISO. Words can be queued while a frame is shifting, so consecutive frames go out back-to-back with no idle cycle. It sits between a word-oriented producer and a serial line driver or link front-end.

## Interface
- `WIDTH`, 16, word width in bits; legal range is WIDTH ≥ 2.
- `LSB_FIRST`, 0, bit order: 0 sends the MSB first, 1 sends the LSB first.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `clr_n`  in  1  reset, asynchronous and active-low.
- `en`  in  1  shift enable; when low, the shifter stalls and holds the current bit.
- `load_valid`  in  1  producer offers `parallel_in`.
- `load_ready`  out  1  holding buffer empty; a load is accepted when `load_valid && load_ready` at the edge.
- `parallel_in`  in  WIDTH  word to serialize.
- `serial_out`  out  1  current serial bit; 0 whenever `serial_valid` = 0.
- `serial_valid`  out  1  high while state is SHIFT.
- `frame_start`  out  1  high while the first bit of a word is on `serial_out`.
- `frame_end`  out  1  high while the last bit of a word is on `serial_out`.

## Operation
- Storage:
  - `hold` (WIDTH) with flag `hold_full`.
  - Shift register `sr` (WIDTH).
  - Bit counter `cnt`, $clog2(WIDTH) bits.
  - Two-state FSM: IDLE, SHIFT.
- `load_ready` = !hold_full. An accepted load writes `hold` and sets `hold_full`.
- IDLE:
  - If `hold_full && en`: copy `sr <= hold`, clear `hold_full`, set `cnt <= 0`, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT with `en` = 1 and `cnt < WIDTH-1`: shift `sr` one place toward the output end, zero-filling; `cnt <= cnt+1`.
- SHIFT with `en` = 1 and `cnt == WIDTH-1`:
  - If `hold_full`: reload `sr` from `hold`, clear `hold_full`, set `cnt <= 0`, stay in SHIFT (gapless).
  - Else go to IDLE.
- SHIFT with `en` = 0: `sr`, `cnt` and state are frozen. Loads into `hold` are still accepted.
- Bit selection: `serial_out` = `sr[WIDTH-1]` when `LSB_FIRST` = 0, else `sr[0]`. It is gated by `serial_valid`.
- Frame markers: `frame_start` = SHIFT && cnt == 0; `frame_end` = SHIFT && cnt == WIDTH-1.
- Simultaneous load and transfer cannot occur, because a transfer requires `hold_full`, which forces `load_ready` = 0. A load in the cycle after a transfer is accepted normally.
- Reset (asynchronous, any time, including mid-frame): state IDLE, `hold_full` 0, `sr` 0, `cnt` 0. The partial word and any buffered word are discarded.

## Timing
- Reset values: `serial_out` 0, `serial_valid` 0, `frame_start` 0, `frame_end` 0, `load_ready` 1.
- Load to first bit, IDLE with `en` = 1: word accepted at edge k; `serial_valid`/`frame_start` rise after edge k+1. Latency is 2 edges.
- A frame with `en` held high occupies exactly WIDTH cycles of `serial_valid`. Each `en`-low cycle adds one cycle.
- Back-to-back: if `hold_full` at the last bit, the next frame's first bit follows in the very next cycle.
- `load_ready` falls the edge after acceptance. It rises the edge after the word transfers into `sr`.
- All outputs are functions of registers only. There is no combinational path from inputs to outputs.

## Structure
- Shared package `serdes_pkg`:
  - State encoding constants `ST_IDLE` = 1'b0, `ST_SHIFT` = 1'b1.
  - Counter-width helper (clog2). The future SIPO successor reuses both.
- One sub-module, `piso_hold_reg`: the holding buffer with its valid/ready logic, WIDTH-parametrised. The FSM, shifter and counter stay in the top level.

## Test plan
- WIDTH=16, LSB_FIRST=0, `en`=1, load 16'hA5A5 → `serial_out` = 1010_0101_1010_0101 over 16 valid cycles; `frame_start` on bit 1 only; `frame_end` on bit 16 only; then `serial_valid` 0.
- Load 16'hA5A5, then 16'h5555 while the first is shifting → 32 contiguous valid cycles with no gap; `frame_start` at cycles 1 and 17.
- LSB_FIRST=1, load 16'h0001 → first bit 1, then 15 zeros; `frame_end` on the 16th bit.
- `en` low for 3 cycles after the 4th bit of 16'hA5A5 → `serial_out` holds 0 (bit 4) for 4 cycles; frame lasts 19 cycles; bit sequence unchanged.
- `en`=0 in IDLE, offer two words (16'h1234, 16'hABCD) → first accepted; `load_ready` drops; second held off; raising `en` sends 16'h1234, then accepts 16'hABCD.
- Assert `clr_n` low at bit 8 of 16'hA5A5 with a word buffered → all outputs 0 immediately; `load_ready` 1; after release, a new load starts cleanly at bit 1.
